// File: rtl/alu.sv
// RV32I integer ALU with branch comparator.
// Combinational result/cond plus one-cycle registered copies.
module alu (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] in1,
  input  logic [31:0] in2,
  input  logic [3:0]  alu_op,
  input  logic [2:0]  funct3,
  output logic [31:0] result,
  output logic        cond,
  output logic [31:0] result_q,
  output logic        cond_q
);

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_SLL   = 4'd2;
  localparam logic [3:0] OP_SLT   = 4'd3;
  localparam logic [3:0] OP_SLTU  = 4'd4;
  localparam logic [3:0] OP_XOR   = 4'd5;
  localparam logic [3:0] OP_SRL   = 4'd6;
  localparam logic [3:0] OP_SRA   = 4'd7;
  localparam logic [3:0] OP_OR    = 4'd8;
  localparam logic [3:0] OP_AND   = 4'd9;
  localparam logic [3:0] OP_PASSB = 4'd10;

  localparam logic [2:0] F3_EQ  = 3'b000;
  localparam logic [2:0] F3_NE  = 3'b001;
  localparam logic [2:0] F3_LT  = 3'b100;
  localparam logic [2:0] F3_GE  = 3'b101;
  localparam logic [2:0] F3_LTU = 3'b110;
  localparam logic [2:0] F3_GEU = 3'b111;

  logic [4:0]  w_shamt;
  logic        w_eq;
  logic        w_lt_s;
  logic        w_lt_u;
  logic [31:0] w_sra;

  assign w_shamt = in2[4:0];
  assign w_eq    = (in1 == in2);
  assign w_lt_s  = ($signed(in1) < $signed(in2));
  assign w_lt_u  = (in1 < in2);
  assign w_sra   = $unsigned($signed(in1) >>> w_shamt);

  always_comb begin
    result = 32'd0;
    unique case (alu_op)
      OP_ADD:   result = in1 + in2;
      OP_SUB:   result = in1 - in2;
      OP_SLL:   result = in1 << w_shamt;
      OP_SLT:   result = {31'd0, w_lt_s};
      OP_SLTU:  result = {31'd0, w_lt_u};
      OP_XOR:   result = in1 ^ in2;
      OP_SRL:   result = in1 >> w_shamt;
      OP_SRA:   result = w_sra;
      OP_OR:    result = in1 | in2;
      OP_AND:   result = in1 & in2;
      OP_PASSB: result = in2;
      default:  result = 32'd0;
    endcase
  end

  // Branch condition ignores alu_op entirely.
  always_comb begin
    cond = 1'b0;
    unique case (funct3)
      F3_EQ:   cond = w_eq;
      F3_NE:   cond = ~w_eq;
      F3_LT:   cond = w_lt_s;
      F3_GE:   cond = ~w_lt_s;
      F3_LTU:  cond = w_lt_u;
      F3_GEU:  cond = ~w_lt_u;
      default: cond = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q <= 32'd0;
      cond_q   <= 1'b0;
    end else begin
      result_q <= result;
      cond_q   <= cond;
    end
  end

endmodule

// File: tb/tb_alu.sv
// Directed bench for alu: combinational checks at drive time,
// registered outputs checked through an expectation queue.
module tb_alu;

  logic        clk;
  logic        rst_n;
  logic [31:0] in1;
  logic [31:0] in2;
  logic [3:0]  alu_op;
  logic [2:0]  funct3;
  logic [31:0] result;
  logic        cond;
  logic [31:0] result_q;
  logic        cond_q;

  typedef struct {
    logic [31:0] r;
    logic        c;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  alu dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in1      (in1),
    .in2      (in2),
    .alu_op   (alu_op),
    .funct3   (funct3),
    .result   (result),
    .cond     (cond),
    .result_q (result_q),
    .cond_q   (cond_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk32(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag,
                      input logic obs,
                      input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Called just after a rising edge: drive, check comb, push,
  // then check the registered copy after the next edge.
  task automatic apply(input string tag,
                       input logic [3:0]  op,
                       input logic [2:0]  f3,
                       input logic [31:0] a,
                       input logic [31:0] b,
                       input logic [31:0] er,
                       input logic        ec);
    exp_t e;
    alu_op = op;
    funct3 = f3;
    in1    = a;
    in2    = b;
    #1;
    chk32({tag, "_res"}, result, er);
    chk1({tag, "_cond"}, cond, ec);
    e.r = er;
    e.c = ec;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s_sb observed empty expected entry", tag);
    end else begin
      e = sb.pop_front();
      chk32({tag, "_res_q"}, result_q, e.r);
      chk1({tag, "_cond_q"}, cond_q, e.c);
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    alu_op = 4'd0;
    funct3 = 3'b000;
    in1    = 32'd2;
    in2    = 32'd3;
    #1;
    chk32("rst_res_q", result_q, 32'd0);
    chk1("rst_cond_q", cond_q, 1'b0);
    chk32("rst_comb_res", result, 32'd5);
    chk1("rst_comb_cond", cond, 1'b0);
    funct3 = 3'b001;
    @(posedge clk);
    #1;
    chk32("rst_hold_res_q", result_q, 32'd0);
    chk1("rst_hold_cond_q", cond_q, 1'b0);
    chk1("rst_comb_ne", cond, 1'b1);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    apply("add_wrap", 4'd0,  3'b000, 32'hFFFFFFFF, 32'd1, 32'h0, 1'b0);
    apply("sub_wrap", 4'd1,  3'b001, 32'h0, 32'd1, 32'hFFFFFFFF, 1'b1);
    apply("sra_msk",  4'd7,  3'b000, 32'h80000000, 32'h21, 32'hC0000000, 1'b0);
    apply("srl_msk",  4'd6,  3'b110, 32'h80000000, 32'h21, 32'h40000000, 1'b0);
    apply("sll_msk",  4'd2,  3'b111, 32'h1, 32'h21, 32'h2, 1'b0);
    apply("slt_neg",  4'd3,  3'b100, 32'hFFFFFFFF, 32'd1, 32'h1, 1'b1);
    apply("sltu_big", 4'd4,  3'b110, 32'hFFFFFFFF, 32'd1, 32'h0, 1'b0);
    apply("geu",      4'd4,  3'b111, 32'hFFFFFFFF, 32'd1, 32'h0, 1'b1);
    apply("f3_010",   4'd3,  3'b010, 32'hFFFFFFFF, 32'd1, 32'h1, 1'b0);
    apply("eq",       4'd0,  3'b000, 32'h1234, 32'h1234, 32'h2468, 1'b1);
    apply("ne",       4'd1,  3'b001, 32'h1234, 32'h1234, 32'h0, 1'b0);
    apply("link",     4'd0,  3'b101, 32'h100, 32'h4, 32'h104, 1'b1);
    apply("op13",     4'd13, 3'b000, 32'h55, 32'h55, 32'h0, 1'b1);
    apply("f3_011",   4'd13, 3'b011, 32'h55, 32'h55, 32'h0, 1'b0);
    apply("xor",      4'd5,  3'b101, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1'b0);
    apply("or",       4'd8,  3'b100, 32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 1'b1);
    apply("and",      4'd9,  3'b110, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b1);
    apply("op15",     4'd15, 3'b001, 32'h1, 32'h2, 32'h0, 1'b1);
    apply("op11",     4'd11, 3'b000, 32'h9, 32'h9, 32'h0, 1'b1);
    apply("op12",     4'd12, 3'b100, 32'h7, 32'h7, 32'h0, 1'b0);
    apply("sll_hi",   4'd2,  3'b000, 32'h3, 32'hFFFFFFE4, 32'h30, 1'b0);
    apply("sra_pos",  4'd7,  3'b101, 32'h7FFFFFFF, 32'h1F, 32'h0, 1'b1);
    apply("sra_neg",  4'd7,  3'b100, 32'h80000000, 32'h1F, 32'hFFFFFFFF, 1'b1);
    apply("srl_zero", 4'd6,  3'b111, 32'hFFFFFFFF, 32'h0, 32'hFFFFFFFF, 1'b1);
    apply("passb",    4'd10, 3'b001, 32'h0, 32'hDEADBEEF, 32'hDEADBEEF, 1'b1);

    // Mid-cycle reset: registered value in flight is dropped.
    alu_op = 4'd10;
    funct3 = 3'b001;
    in1    = 32'h0;
    in2    = 32'hCAFEF00D;
    #2;
    rst_n = 1'b0;
    #1;
    chk32("async_res_q", result_q, 32'd0);
    chk1("async_cond_q", cond_q, 1'b0);
    chk32("rst_follow_res", result, 32'hCAFEF00D);
    chk1("rst_follow_cond", cond, 1'b1);
    sb.delete();
    @(posedge clk);
    #1;
    chk32("rst_edge_res_q", result_q, 32'd0);
    chk1("rst_edge_cond_q", cond_q, 1'b0);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    apply("recover",  4'd0,  3'b000, 32'h10, 32'h20, 32'h30, 1'b0);

    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("FAIL sb_drain observed %0d expected 0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu.md
ALU -- requirements
Module: alu

Interface
REQ-001 SHALL have ports: clk  input  1  rising-edge clock.
REQ-002 SHALL have ports: rst_n  input  1  asynchronous, active-low reset; clears registered outputs only.
REQ-003 SHALL have ports: in1  input  32  first operand (rs1 value or PC).
REQ-004 SHALL have ports: in2  input  32  second operand (rs2 value, immediate, or constant 4).
REQ-005 SHALL have ports: alu_op  input  4  operation select, per REQ-012.
REQ-006 SHALL have ports: funct3  input  3  branch comparison select, per REQ-015.
REQ-007 SHALL have ports: result  output  32  combinational operation result.
REQ-008 SHALL have ports: cond  output  1  combinational branch-condition result.
REQ-009 SHALL have ports: result_q  output  32  result registered on clk.
REQ-010 SHALL have ports: cond_q  output  1  cond registered on clk.
REQ-011 SHALL have no parameters; widths are fixed.

Function
REQ-012 The alu_op encoding SHALL be:
- 0 ADD: in1+in2
- 1 SUB: in1-in2
- 2 SLL: in1<<in2[4:0]
- 3 SLT: signed in1<in2 ? 1 : 0
- 4 SLTU: unsigned compare, same form as SLT
- 5 XOR
- 6 SRL: logical in1>>in2[4:0]
- 7 SRA: arithmetic in1>>>in2[4:0]
- 8 OR
- 9 AND
- 10 PASSB: in2
REQ-013 alu_op 11-15 SHALL drive result=0.
REQ-014 Arithmetic SHALL be modulo 2^32: no overflow flag, carry discarded, wrap-around silent; shifts SHALL use only in2[4:0], ignoring in2[31:5].
REQ-015 cond SHALL depend only on in1, in2 and funct3, independent of alu_op:
- 000 EQ
- 001 NE
- 100 signed LT
- 101 signed GE
- 110 unsigned LT
- 111 unsigned GE
- 010/011 → 0
REQ-016 result and cond SHALL be purely combinational: zero latency, valid in the same cycle the inputs change, no latches.
REQ-017 On each rising clk edge with rst_n high, result_q SHALL take result and cond_q SHALL take cond; latency is one cycle, and the registers are updated on every edge with no enable.
REQ-018 SLT/SLTU outputs SHALL be zero-extended to 32 bits (bit0 = comparison, bits 31:1 = 0).

Reset
REQ-019 While rst_n is low, result_q and cond_q SHALL be 0 immediately (asynchronous), independent of clk.
REQ-020 result and cond SHALL be unaffected by rst_n and SHALL follow the inputs during reset.
REQ-021 Deassertion of rst_n SHALL take effect on the next rising clk edge; if rst_n is asserted mid-operation, the registered value in flight SHALL be discarded.

Verification
REQ-022 Arithmetic/wrap: alu_op=0, in1=0xFFFFFFFF, in2=1 -> result=0x00000000. alu_op=1, in1=0, in2=1 -> result=0xFFFFFFFF.
REQ-023 Shifts: in1=0x80000000, in2=0x00000021.
- alu_op=7 -> result=0xC0000000.
- alu_op=6 -> result=0x40000000.
- alu_op=2, in1=1 -> result=0x00000002.
REQ-024 Compare: in1=0xFFFFFFFF, in2=1.
- alu_op=3 -> result=1; alu_op=4 -> result=0.
- funct3=100 -> cond=1; funct3=110 -> cond=0; funct3=111 -> cond=1.
- funct3=010 -> cond=0.
REQ-025 Equality/jump: in1=in2=0x1234.
- funct3=000 -> cond=1; funct3=001 -> cond=0.
- alu_op=0, in1=0x100, in2=4 -> result=0x104 (link address).
REQ-026 Registered path: with rst_n high, apply alu_op=10, in2=0xDEADBEEF -> result_q=0xDEADBEEF after 1 edge. Then drop rst_n between edges -> result_q=0 and cond_q=0 at once, with no clk edge needed.
REQ-027 Unused alu_op: alu_op=13, any operands -> result=0; cond still follows funct3.
